// File: rtl/frame_ram_arbiter.sv
// ============================================================================
// Module   : frame_ram_arbiter
// Brief    : Single-port frame RAM owner. Video fetch has absolute priority,
//            then the clear-screen sweep, then round-robin game writes.
//            Optional FRAME_COLLISION_EN: head writes read-check-write the cell.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_ram_arbiter #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 3,
    parameter int DEPTH      = 4800,
    parameter int NREQ       = 3
) (
    input  logic                       px_clk,
    input  logic                       rst,
    input  logic                       vid_req,
    input  logic [ADDR_WIDTH-1:0]      vid_addr,
    output logic [DATA_WIDTH-1:0]      vid_data,
    output logic                       vid_valid,
    input  logic [NREQ-1:0]            wr_req,
    input  logic [NREQ*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] wr_data,
    output logic [NREQ-1:0]            wr_ack,
    input  logic                       clr_start,
    output logic                       clr_busy,
    output logic [ADDR_WIDTH-1:0]      ram_addr,
    output logic                       ram_write,
    output logic [DATA_WIDTH-1:0]      ram_wdata,
    input  logic [DATA_WIDTH-1:0]      ram_rdata,
    output logic                       collision
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDR_WIDTH-1:0] c_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ONE  = ADDR_WIDTH'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_CLEAR  = 2'd1;
`ifdef FRAME_COLLISION_EN
    localparam logic [1:0] c_HWRITE = 2'd2;
`endif

    logic [1:0]            r_state;
    logic [c_PTR_W-1:0]    r_ptr;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  r_vid_valid;

    logic [ADDR_WIDTH-1:0] w_addr_arr [NREQ];
    logic [DATA_WIDTH-1:0] w_data_arr [NREQ];
    logic                  w_any;
    logic [c_PTR_W-1:0]    w_gnt_idx;
    logic [c_PTR_W-1:0]    w_cand_idx;
    int                    w_sum;
    logic                  w_grant;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_addr_arr[gi] = wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_data_arr[gi] = wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // First requester at or after the pointer, wrapping modulo NREQ
    always_comb begin
        w_any      = 1'b0;
        w_gnt_idx  = '0;
        w_sum      = 0;
        w_cand_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sum = int'(r_ptr) + i;
            if (w_sum >= NREQ) begin
                w_sum = w_sum - NREQ;
            end
            w_cand_idx = c_PTR_W'(w_sum);
            if (!w_any && wr_req[w_cand_idx]) begin
                w_any     = 1'b1;
                w_gnt_idx = w_cand_idx;
            end
        end
    end

`ifdef FRAME_COLLISION_EN
    logic r_fresh;
    logic r_hit;
    logic r_collision;
    logic w_hit;
    logic w_hread;
    logic w_hwrite;

    // Only the first HWRITE cycle sees the HREAD data; retries reuse r_hit
    assign w_hit = r_fresh ? (ram_rdata != '0) : r_hit;
`endif

    // Outputs are forced idle while reset is held so no write escapes it
    always_comb begin
        ram_addr  = vid_addr;
        ram_write = 1'b0;
        ram_wdata = '0;
        wr_ack    = '0;
        w_grant   = 1'b0;
`ifdef FRAME_COLLISION_EN
        w_hread   = 1'b0;
        w_hwrite  = 1'b0;
`endif
        if (rst || vid_req) begin
            ram_addr = vid_addr;
        end else if (r_state == c_CLEAR) begin
            ram_addr  = r_clr_cnt;
            ram_write = 1'b1;
`ifdef FRAME_COLLISION_EN
        end else if (r_state == c_HWRITE) begin
            ram_addr  = w_addr_arr[0];
            ram_write = 1'b1;
            ram_wdata = w_data_arr[0];
            wr_ack[0] = 1'b1;
            w_hwrite  = 1'b1;
`endif
        end else if (r_state == c_IDLE && !clr_start && w_any) begin
            ram_addr = w_addr_arr[w_gnt_idx];
`ifdef FRAME_COLLISION_EN
            // The head's arbitration cycle doubles as its read cycle
            if (w_gnt_idx == '0) begin
                w_hread = 1'b1;
            end else
`endif
            begin
                ram_write         = 1'b1;
                ram_wdata         = w_data_arr[w_gnt_idx];
                wr_ack[w_gnt_idx] = 1'b1;
                w_grant           = 1'b1;
            end
        end
    end

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_ptr       <= '0;
            r_clr_cnt   <= '0;
            r_vid_valid <= 1'b0;
        end else begin
            r_vid_valid <= vid_req;
            case (r_state)
                c_IDLE: begin
                    if (clr_start) begin
                        r_state <= c_CLEAR;
                    end else if (w_grant) begin
                        r_ptr <= c_PTR_W'((int'(w_gnt_idx) + 1) % NREQ);
`ifdef FRAME_COLLISION_EN
                    end else if (w_hread) begin
                        r_state <= c_HWRITE;
`endif
                    end
                end
                c_CLEAR: begin
                    if (!vid_req) begin
                        if (r_clr_cnt == c_LAST) begin
                            r_state   <= c_IDLE;
                            r_clr_cnt <= '0;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + c_ONE;
                        end
                    end
                end
`ifdef FRAME_COLLISION_EN
                c_HWRITE: begin
                    if (!vid_req) begin
                        r_state <= c_IDLE;
                        r_ptr   <= c_PTR_W'(1 % NREQ);
                    end
                end
`endif
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef FRAME_COLLISION_EN
    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            r_fresh     <= 1'b0;
            r_hit       <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            if (w_hread) begin
                r_fresh <= 1'b1;
            end else if (r_state == c_HWRITE) begin
                r_fresh <= 1'b0;
            end
            if (r_state == c_HWRITE) begin
                r_hit <= w_hit;
            end
            if (clr_start) begin
                r_collision <= 1'b0;
            end else if (w_hwrite && w_hit) begin
                r_collision <= 1'b1;
            end
        end
    end

    assign collision = r_collision;
`else
    assign collision = 1'b0;
`endif

    assign vid_data  = ram_rdata;
    assign vid_valid = r_vid_valid;
    assign clr_busy  = (r_state == c_CLEAR);

endmodule

`default_nettype wire

// File: tb/tb_frame_ram_arbiter.sv
// ============================================================================
// Module   : tb_frame_ram_arbiter
// Brief    : Directed scoreboard bench for frame_ram_arbiter with a behavioural
//            synchronous-read frame RAM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_frame_ram_arbiter;

    localparam int AW = 13;
    localparam int DW = 3;
    localparam int DEPTH = 4800;
    localparam int NREQ = 3;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic                 px_clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 vid_req = 1'b0;
    logic [AW-1:0]        vid_addr = '0;
    logic [DW-1:0]        vid_data;
    logic                 vid_valid;
    logic [NREQ-1:0]      wr_req = '0;
    logic [NREQ*AW-1:0]   wr_addr = '0;
    logic [NREQ*DW-1:0]   wr_data = '0;
    logic [NREQ-1:0]      wr_ack;
    logic                 clr_start = 1'b0;
    logic                 clr_busy;
    logic [AW-1:0]        ram_addr;
    logic                 ram_write;
    logic [DW-1:0]        ram_wdata;
    logic [DW-1:0]        ram_rdata;
    logic                 collision;

    logic [DW-1:0] mem [DEPTH];
    wr_t           exp_q [$];
    logic [2:0]    ack_q [$];
    logic [2:0]    vid_q [$];
    logic          tb_vreq_d = 1'b0;
    int            n_tests = 0;
    int            n_fail = 0;

    frame_ram_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .NREQ       (NREQ)
    ) dut (
        .px_clk    (px_clk),
        .rst       (rst),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_valid (vid_valid),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .ram_addr  (ram_addr),
        .ram_write (ram_write),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .collision (collision)
    );

    always #5 px_clk = ~px_clk;

    // Frame RAM: synchronous read, one cycle latency; cells 500..599 preloaded
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = (i >= 500 && i < 600) ? DW'((i % 7) + 1) : '0;
        end
        forever begin
            @(posedge px_clk);
            if (ram_write) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    always @(posedge px_clk or posedge rst) begin
        if (rst) tb_vreq_d <= 1'b0;
        else     tb_vreq_d <= vid_req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitors, sampled mid-cycle
    always @(negedge px_clk) begin
        wr_t  e;
        logic [2:0] ea;
        logic [2:0] ev;
        if (ram_write) begin
            if (exp_q.size() == 0) chk("wr_unexpected", 32'(ram_addr), 32'hFFFF);
            else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(e.a));
                chk("wr_data", 32'(ram_wdata), 32'(e.d));
            end
        end
        if (wr_ack != '0) begin
            chk("ack_onehot", 32'($onehot(wr_ack)), 32'd1);
            if (ack_q.size() == 0) chk("ack_unexpected", 32'(wr_ack), 32'd0);
            else begin
                ea = ack_q.pop_front();
                chk("ack", 32'(wr_ack), 32'(ea));
            end
        end
        if (wr_req != '0 && (vid_req || clr_busy)) chk("ack_stall", 32'(wr_ack), 32'd0);
        chk("vid_valid", 32'(vid_valid), 32'(tb_vreq_d));
        if (vid_valid) begin
            if (vid_q.size() == 0) chk("vid_unexpected", 32'(vid_data), 32'hFFFF);
            else begin
                ev = vid_q.pop_front();
                chk("vid_data", 32'(vid_data), 32'(ev));
            end
        end
    end

    task automatic run_writes();
        logic [2:0] a;
        for (int c = 0; c < 20 && wr_req != '0; c++) begin
            @(negedge px_clk);
            a = wr_ack;
            @(posedge px_clk); #1;
            wr_req = wr_req & ~a;
        end
        chk("wr_drain", 32'(wr_req), 32'd0);
    endtask

    task automatic vid_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
        @(posedge px_clk); #1;
        vid_req = 1'b1;
        vid_addr = a;
        vid_q.push_back(e);
        @(posedge px_clk); #1;
        vid_req = 1'b0;
    endtask

    task automatic push_clear(input int last);
        for (int a = 0; a <= last; a++) exp_q.push_back('{a: AW'(a), d: '0});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  busy_cycles;
        logic tog;
        logic restart;

        // Reset, with all writers requesting: nothing may reach the RAM
        wr_req = 3'b111;
        wr_addr = {13'd12, 13'd11, 13'd10};
        wr_data = {3'd7, 3'd6, 3'd5};
        #1 rst = 1'b1;
        @(negedge px_clk);
        chk("rst_clr_busy", 32'(clr_busy), 32'd0);
        chk("rst_ram_write", 32'(ram_write), 32'd0);
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        chk("rst_vid_valid", 32'(vid_valid), 32'd0);
        chk("rst_collision", 32'(collision), 32'd0);

        // Video owns the port every cycle: no acks, read data follows by one
        @(posedge px_clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            vid_req = 1'b1;
            vid_addr = AW'(500 + i);
            vid_q.push_back(mem[500 + i]);
            @(posedge px_clk); #1;
        end

        // Round robin from pointer 0
        ack_q.push_back(3'b001);
        ack_q.push_back(3'b010);
        ack_q.push_back(3'b100);
        exp_q.push_back('{a: 13'd10, d: 3'd5});
        exp_q.push_back('{a: 13'd11, d: 3'd6});
        exp_q.push_back('{a: 13'd12, d: 3'd7});
        vid_req = 1'b0;
        run_writes();
        vid_read(13'd10, 3'd5);
        vid_read(13'd11, 3'd6);
        vid_read(13'd12, 3'd7);

        // Clear sweep with alternating video steals, restart at 2000 ignored,
        // pending requester 1 must wait until the sweep is done
        @(posedge px_clk); #1;
        clr_start = 1'b1;
        wr_req = 3'b010;
        wr_addr = {13'd0, 13'd4000, 13'd0};
        wr_data = {3'd0, 3'd4, 3'd0};
        push_clear(DEPTH - 1);
        exp_q.push_back('{a: 13'd4000, d: 3'd4});
        ack_q.push_back(3'b010);
        @(posedge px_clk); #1;
        clr_start = 1'b0;
        busy_cycles = 0;
        tog = 1'b1;
        restart = 1'b0;
        for (int c = 0; c < 12000; c++) begin
            if (c > 0) begin
                @(posedge px_clk); #1;
            end
            vid_req = tog;
            vid_addr = 13'd300;
            clr_start = restart;
            restart = 1'b0;
            if (tog) vid_q.push_back(mem[300]);
            tog = ~tog;
            @(negedge px_clk);
            if (!clr_busy) break;
            busy_cycles++;
            if (ram_write && ram_addr == 13'd2000) restart = 1'b1;
        end
        chk("clr_busy_cycles", 32'(busy_cycles), 32'd9600);
        @(posedge px_clk); #1;
        vid_req = 1'b0;
        clr_start = 1'b0;
        run_writes();
        chk("clr_queue_empty", 32'(exp_q.size()), 32'd0);
        vid_read(13'd100, 3'd0);
        vid_read(13'd4799, 3'd0);
        vid_read(13'd550, 3'd0);
        vid_read(13'd4000, 3'd4);

        // Asynchronous reset in the middle of a sweep
        @(posedge px_clk); #1;
        clr_start = 1'b1;
        push_clear(1234);
        @(posedge px_clk); #1;
        clr_start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge px_clk);
            if (ram_write && ram_addr == 13'd1234) break;
        end
        #1 rst = 1'b1;
        #1;
        chk("midrst_clr_busy", 32'(clr_busy), 32'd0);
        chk("midrst_ram_write", 32'(ram_write), 32'd0);
        @(posedge px_clk); #1;
        rst = 1'b0;
        @(negedge px_clk);
        chk("postrst_idle", 32'(clr_busy), 32'd0);
        chk("postrst_queue", 32'(exp_q.size()), 32'd0);

        // Pointer back at 0 after reset: requester 1 goes before 2
        @(posedge px_clk); #1;
        wr_req = 3'b110;
        wr_addr = {13'd21, 13'd20, 13'd0};
        wr_data = {3'd2, 3'd3, 3'd0};
        ack_q.push_back(3'b010);
        ack_q.push_back(3'b100);
        exp_q.push_back('{a: 13'd20, d: 3'd3});
        exp_q.push_back('{a: 13'd21, d: 3'd2});
        run_writes();

`ifdef FRAME_COLLISION_EN
        // Head write to an empty cell: read-then-write, no collision
        @(posedge px_clk); #1;
        wr_req = 3'b001;
        wr_addr = {13'd0, 13'd0, 13'd2025};
        wr_data = {3'd0, 3'd0, 3'd3};
        ack_q.push_back(3'b001);
        exp_q.push_back('{a: 13'd2025, d: 3'd3});
        run_writes();
        chk("coll_empty_cell", 32'(collision), 32'd0);

        // Head write onto the occupied cell with one video steal of HWRITE
        @(posedge px_clk); #1;
        wr_req = 3'b001;
        wr_data = {3'd0, 3'd0, 3'd1};
        @(negedge px_clk);
        chk("hread_write", 32'(ram_write), 32'd0);
        chk("hread_addr", 32'(ram_addr), 32'd2025);
        @(posedge px_clk); #1;
        vid_req = 1'b1;
        vid_addr = 13'd100;
        vid_q.push_back(3'd0);
        ack_q.push_back(3'b001);
        exp_q.push_back('{a: 13'd2025, d: 3'd1});
        @(posedge px_clk); #1;
        vid_req = 1'b0;
        run_writes();
        chk("coll_set", 32'(collision), 32'd1);

        // Another head write to an empty cell keeps the sticky flag
        @(posedge px_clk); #1;
        wr_req = 3'b001;
        wr_addr = {13'd0, 13'd0, 13'd3000};
        wr_data = {3'd0, 3'd0, 3'd2};
        ack_q.push_back(3'b001);
        exp_q.push_back('{a: 13'd3000, d: 3'd2});
        run_writes();
        chk("coll_sticky", 32'(collision), 32'd1);

        // clr_start clears the flag
        @(posedge px_clk); #1;
        clr_start = 1'b1;
        push_clear(DEPTH - 1);
        @(posedge px_clk); #1;
        clr_start = 1'b0;
        @(negedge px_clk);
        chk("coll_cleared", 32'(collision), 32'd0);
        chk("coll_clr_busy", 32'(clr_busy), 32'd1);
        for (int c = 0; c < 6000 && clr_busy; c++) @(negedge px_clk);
        chk("coll_sweep_done", 32'(clr_busy), 32'd0);
`else
        chk("coll_tied_off", 32'(collision), 32'd0);
`endif

        repeat (3) @(posedge px_clk);
        #1;
        chk("final_wr_queue", 32'(exp_q.size()), 32'd0);
        chk("final_ack_queue", 32'(ack_q.size()), 32'd0);
        chk("final_vid_queue", 32'(vid_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/frame_ram_arbiter.md
Name: frame_ram_arbiter

Overview:
- Owns the single port of the 80x60 frame RAM (4800 x 3-bit sprite indices).
- Shares it between three requesters:
  - the video fetch path, which has absolute priority;
  - a clear-screen sweep sequencer;
  - NREQ game-logic write requesters (0 = head, 1 = tail, 2 = food) under round-robin.
- Sits between the snake game/drawing logic and the sram instance. The RAM is synchronous-read with 1-cycle latency.

Parameters:
ADDR_WIDTH, 13, frame RAM address width
DATA_WIDTH, 3, sprite index width
DEPTH, 4800, number of frame cells swept by clear
NREQ, 3, number of game write requesters

Ports:
px_clk  in  1  pixel clock; the only clock
rst  in  1  reset, asynchronous, active-high
vid_req  in  1  video fetch wants the port this cycle
vid_addr  in  ADDR_WIDTH  video fetch address
vid_data  out  DATA_WIDTH  read data for the fetch issued the previous cycle
vid_valid  out  1  vid_data valid (vid_req delayed one cycle)
wr_req  in  NREQ  per-requester write request, level, held until ack
wr_addr  in  NREQ*ADDR_WIDTH  packed addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
wr_data  in  NREQ*DATA_WIDTH  packed write data
wr_ack  out  NREQ  one-cycle pulse in the cycle requester k's write is driven to RAM
clr_start  in  1  single-cycle pulse; start clear sweep
clr_busy  out  1  clear sweep in progress
ram_addr  out  ADDR_WIDTH  RAM address
ram_write  out  1  RAM write enable
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM read data (1-cycle latency)
collision  out  1  sticky head-collision flag (FRAME_COLLISION_EN only; tied 0 otherwise)

Behaviour:
- Reset (async, rst=1) sets:
  - state IDLE, round-robin pointer 0, clear counter 0;
  - wr_ack=0, clr_busy=0, vid_valid=0, ram_write=0, collision=0.
- Port mux (combinational, per cycle, in priority order):
  1. vid_req=1: ram_addr=vid_addr, ram_write=0. Every other requester stalls; state, pointer and counter hold.
  2. Otherwise, state CLEAR: write 0 to the clear counter address.
  3. Otherwise, state IDLE and any wr_req: grant the first set bit at or after the pointer, wrapping modulo NREQ. Drive ram_addr/ram_wdata from that requester, set ram_write=1, pulse wr_ack[k]. Next cycle the pointer = (k+1) mod NREQ.
  4. Otherwise: ram_write=0, ram_addr=vid_addr.
- vid_data = ram_rdata. vid_valid is registered vid_req; latency from vid_req to vid_valid is exactly 1 cycle.
- At most one wr_ack bit is high in any cycle. No ack is given while vid_req=1 or clr_busy=1.
- FSM:
  - IDLE -> CLEAR on clr_start.
  - CLEAR: the counter advances only on cycles the sweep owns the port. After writing address DEPTH-1, return to IDLE and zero the counter. clr_busy=1 exactly while in CLEAR.
  - clr_start while in CLEAR is ignored; the counter is not restarted.
  - clr_start arriving together with a pending wr_req in IDLE: the clear wins. The write is not acked until the sweep finishes.
- Reset mid-sweep or mid-handshake: all state drops immediately. Requesters must re-present their requests.
- Every write is single-cycle. Requesters sample wr_ack on the px_clk edge and may change req/addr/data the following cycle.

Optional Feature:
FRAME_COLLISION_EN
- Defined: a grant to requester 0 (head) becomes two RAM cycles.
  - HREAD: read at wr_addr[0], ram_write=0.
  - HWRITE: if ram_rdata != 0, set collision (sticky); then write and pulse wr_ack[0].
  - If vid_req steals HWRITE, stay in HWRITE, keeping the already-sampled comparison result, and retry.
  - collision clears on reset or clr_start.
- Undefined: requester 0 is treated like the others; collision is constant 0; HREAD/HWRITE do not exist.

Test Plan:
- vid_req=1 every cycle with wr_req=3'b111 -> no wr_ack for 20 cycles. vid_valid follows vid_req by 1 cycle; vid_data equals the RAM contents at vid_addr.
- wr_req=3'b111 held (requesters drop req after their ack), vid_req=0, pointer=0 -> acks in order 001, 010, 100. Matching RAM writes land at the three addresses with their data.
- clr_start with vid_req toggling 1/0 every cycle -> exactly 4800 zero writes, addresses 0..4799 in order. clr_busy high for 9600 cycles; then cells 100 and 4799 read 0.
- clr_start pulsed again at sweep address 2000 -> no restart; sweep ends after address 4799.
- rst asserted at sweep address 1234 -> clr_busy=0 and ram_write=0 immediately (asynchronous); state IDLE.
- FRAME_COLLISION_EN: preload cell 2025=3, head writes 1 to 2025 -> HREAD then HWRITE; collision=1 stays set; a head write to an empty cell leaves collision unchanged; clr_start clears it.
